// File: rtl/phase_shift_multi.sv
// Cycle-based multi-channel phase shifter clocked by the VCO tick clock: per-channel
// period/phase/duty, lock detection and a one-tick dynamic phase-shift handshake.
module phase_shift_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int LOCK_CYCLES = 3,
    parameter int PS_LATENCY  = 12
) (
    input  logic                                            clk,
    input  logic                                            RST_N,
    input  logic                                            PWRDWN,
    input  logic                                            load,
    input  logic [CHANNELS*CNT_WIDTH-1:0]                   period_ticks,
    input  logic [CHANNELS*10-1:0]                          shift,
    input  logic [CHANNELS*7-1:0]                           duty_cycle,
    input  logic                                            PSEN,
    input  logic                                            PSINCDEC,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] PSCHAN,
    output logic [CHANNELS-1:0]                             clk_shifted,
    output logic                                            lock,
    output logic                                            PSDONE
);

    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW  = CNT_WIDTH + 10;
    localparam int WCW = $clog2(LOCK_CYCLES + 1);
    localparam int PCW = $clog2(PS_LATENCY + 1);

    logic [CNT_WIDTH-1:0] cfg_period [CHANNELS];
    logic [CNT_WIDTH-1:0] cfg_offset [CHANNELS];
    logic [CNT_WIDTH-1:0] cfg_high   [CHANNELS];
    logic [CNT_WIDTH-1:0] new_period [CHANNELS];
    logic [CNT_WIDTH-1:0] new_offset [CHANNELS];
    logic [CNT_WIDTH-1:0] new_high   [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt        [CHANNELS];
    logic [CNT_WIDTH-1:0] dyn        [CHANNELS];
    logic [WCW-1:0]       wraps      [CHANNELS];

    logic                 configured;
    logic [CHANNELS-1:0]  phase_hi;
    logic [CHANNELS-1:0]  at_end;
    logic [CHANNELS-1:0]  saturated;

    logic                 busy;
    logic                 discard;
    logic                 req_inc;
    logic [CHW-1:0]       req_chan;
    logic [PCW-1:0]       ps_cnt;

    // Shift is folded into 0..359 with add/subtract steps; the 10-bit range needs at most two.
    always_comb begin : cfg_calc
        logic [CNT_WIDTH-1:0] p;
        logic signed [10:0]   deg;
        logic [PW-1:0]        prod;
        logic [PW-1:0]        hi;
        p    = '0;
        deg  = '0;
        prod = '0;
        hi   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            p = period_ticks[i*CNT_WIDTH +: CNT_WIDTH];
            if (p < CNT_WIDTH'(2))
                p = CNT_WIDTH'(2);
            deg = {shift[i*10+9], shift[i*10 +: 10]};
            if (deg < 0)
                deg = deg + 11'sd360;
            if (deg < 0)
                deg = deg + 11'sd360;
            if (deg >= 11'sd360)
                deg = deg - 11'sd360;
            prod = PW'(deg[8:0]) * PW'(p);
            hi   = (PW'(duty_cycle[i*7 +: 7]) * PW'(p)) / PW'(100);
            if (hi < PW'(1))
                hi = PW'(1);
            else if (hi > PW'(p) - PW'(1))
                hi = PW'(p) - PW'(1);
            new_period[i] = p;
            new_offset[i] = CNT_WIDTH'(prod / PW'(360));
            new_high[i]   = CNT_WIDTH'(hi);
        end
    end

    always_comb begin : phase_calc
        logic [CNT_WIDTH:0] tot;
        logic [CNT_WIDTH:0] pos;
        tot       = '0;
        pos       = '0;
        phase_hi  = '0;
        at_end    = '0;
        saturated = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            tot = {1'b0, cfg_offset[i]} + {1'b0, dyn[i]};
            if (tot >= {1'b0, cfg_period[i]})
                tot = tot - {1'b0, cfg_period[i]};
            if ({1'b0, cnt[i]} >= tot)
                pos = {1'b0, cnt[i]} - tot;
            else
                pos = {1'b0, cnt[i]} + {1'b0, cfg_period[i]} - tot;
            phase_hi[i]  = (pos < {1'b0, cfg_high[i]});
            at_end[i]    = (cnt[i] == cfg_period[i] - CNT_WIDTH'(1));
            saturated[i] = (wraps[i] == WCW'(LOCK_CYCLES));
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cfg_period[i] <= '0;
                cfg_offset[i] <= '0;
                cfg_high[i]   <= '0;
                cnt[i]        <= '0;
                dyn[i]        <= '0;
                wraps[i]      <= '0;
            end
            configured  <= 1'b0;
            clk_shifted <= '0;
            lock        <= 1'b0;
            PSDONE      <= 1'b0;
            busy        <= 1'b0;
            discard     <= 1'b0;
            req_inc     <= 1'b0;
            req_chan    <= '0;
            ps_cnt      <= '0;
        end else begin
            if (load) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    cfg_period[i] <= new_period[i];
                    cfg_offset[i] <= new_offset[i];
                    cfg_high[i]   <= new_high[i];
                end
                configured <= 1'b1;
            end

            // Holding the counters at zero makes the first cycle after power-down behave as a load.
            if (PWRDWN) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    cnt[i]   <= '0;
                    dyn[i]   <= '0;
                    wraps[i] <= '0;
                end
                clk_shifted <= '0;
                lock        <= 1'b0;
                PSDONE      <= 1'b0;
                busy        <= 1'b0;
                discard     <= 1'b0;
                ps_cnt      <= '0;
            end else begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (load) begin
                        cnt[i]   <= '0;
                        dyn[i]   <= '0;
                        wraps[i] <= '0;
                    end else if (configured) begin
                        if (at_end[i]) begin
                            cnt[i] <= '0;
                            if (!saturated[i])
                                wraps[i] <= wraps[i] + WCW'(1);
                        end else begin
                            cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                        end
                    end
                end
                clk_shifted <= configured ? phase_hi : '0;
                lock        <= configured && !load && (&saturated);

                PSDONE <= 1'b0;
                if (busy) begin
                    // Busy is held through the PSDONE cycle so a new request lands one cycle later.
                    if (PSDONE) begin
                        busy    <= 1'b0;
                        discard <= 1'b0;
                    end else begin
                        if (ps_cnt == PCW'(PS_LATENCY - 1)) begin
                            PSDONE <= 1'b1;
                            if (!discard && !load) begin
                                for (int unsigned i = 0; i < CHANNELS; i++) begin
                                    if (req_chan == CHW'(i)) begin
                                        if (req_inc)
                                            dyn[i] <= (dyn[i] == cfg_period[i] - CNT_WIDTH'(1)) ?
                                                      '0 : dyn[i] + CNT_WIDTH'(1);
                                        else
                                            dyn[i] <= (dyn[i] == '0) ?
                                                      cfg_period[i] - CNT_WIDTH'(1) : dyn[i] - CNT_WIDTH'(1);
                                    end
                                end
                            end
                        end else begin
                            ps_cnt <= ps_cnt + PCW'(1);
                        end
                        if (load)
                            discard <= 1'b1;
                    end
                end else if (PSEN) begin
                    busy     <= 1'b1;
                    ps_cnt   <= PCW'(1);
                    req_chan <= PSCHAN;
                    req_inc  <= PSINCDEC;
                    discard  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_shift_multi.sv
// Directed bench for phase_shift_multi with three channels (leaves PSCHAN=3 out of range).
module tb_phase_shift_multi;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        PWRDWN;
    logic        load;
    logic [47:0] period_ticks;
    logic [29:0] shift;
    logic [20:0] duty_cycle;
    logic        PSEN;
    logic        PSINCDEC;
    logic [1:0]  PSCHAN;
    logic [2:0]  clk_shifted;
    logic        lock;
    logic        PSDONE;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    phase_shift_multi #(
        .CHANNELS   (3),
        .CNT_WIDTH  (16),
        .LOCK_CYCLES(3),
        .PS_LATENCY (12)
    ) dut (
        .clk         (clk),
        .RST_N       (RST_N),
        .PWRDWN      (PWRDWN),
        .load        (load),
        .period_ticks(period_ticks),
        .shift       (shift),
        .duty_cycle  (duty_cycle),
        .PSEN        (PSEN),
        .PSINCDEC    (PSINCDEC),
        .PSCHAN      (PSCHAN),
        .clk_shifted (clk_shifted),
        .lock        (lock),
        .PSDONE      (PSDONE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cfg(input int p0, input int p1, input int p2,
                       input int s0, input int s1, input int s2,
                       input int d0, input int d1, input int d2);
        period_ticks = {16'(p2), 16'(p1), 16'(p0)};
        shift        = {10'(s2), 10'(s1), 10'(s0)};
        duty_cycle   = {7'(d2), 7'(d1), 7'(d0)};
    endtask

    task automatic do_load();
        load = 1'b1;
        tick();
        load = 1'b0;
        cyc  = 1;
    endtask

    function automatic logic [127:0] lowmask(input int h);
        return (128'd1 << h) - 128'd1;
    endfunction

    // Output in cycle n reflects counter value (n-2) mod P of each channel.
    task automatic check_wave(input int n, input int p0, input int p1, input int p2,
                              input logic [127:0] w0, input logic [127:0] w1,
                              input logic [127:0] w2, input string tag);
        logic [2:0] e;
        for (int k = 0; k < n; k++) begin
            tick();
            e = {w2[(cyc-2)%p2], w1[(cyc-2)%p1], w0[(cyc-2)%p0]};
            chk(tag, 32'(clk_shifted), 32'(e));
        end
    endtask

    task automatic wait_lock(input int rise, input string tag);
        while (cyc < rise - 1)
            tick();
        chk({tag, "_pre"}, 32'(lock), 32'd0);
        tick();
        chk(tag, 32'(lock), 32'd1);
    endtask

    task automatic ps_request(input logic [1:0] ch, input logic inc);
        PSCHAN   = ch;
        PSINCDEC = inc;
        PSEN     = 1'b1;
        tick();
        PSEN     = 1'b0;
    endtask

    initial begin
        RST_N = 1'b1; PWRDWN = 1'b0; load = 1'b0; PSEN = 1'b0; PSINCDEC = 1'b0; PSCHAN = '0;
        cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 RST_N = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_clk", 32'(clk_shifted), 32'd0);
        chk("reset_lock", 32'(lock), 32'd0);
        chk("reset_psdone", 32'(PSDONE), 32'd0);
        RST_N = 1'b1;
        repeat (3) tick();
        chk("preload_clk", 32'(clk_shifted), 32'd0);
        chk("preload_lock", 32'(lock), 32'd0);

        // Shift 90 / 0 / -90 on P=8, duty 50: offsets 2, 0, 6; high 4.
        cfg(8, 8, 8, 90, 0, -90, 50, 50, 50);
        do_load();
        check_wave(16, 8, 8, 8, 8'b0011_1100, 8'b0000_1111, 8'b1100_0011, "wave_shift");
        wait_lock(26, "lock_p8");

        // Increment ch1; a second request while busy must be ignored.
        ps_request(2'd1, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) tick();
            chk("psdone_inc", 32'(PSDONE), 32'(k == 12));
            if (k == 3) begin PSCHAN = 2'd0; PSINCDEC = 1'b0; PSEN = 1'b1; end
            if (k == 4) PSEN = 1'b0;
        end
        check_wave(16, 8, 8, 8, 8'b0011_1100, 8'b0001_1110, 8'b1100_0011, "wave_ps_inc");

        // Out-of-range channel: PSDONE only.
        ps_request(2'd3, 1'b1);
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) tick();
            chk("psdone_oor", 32'(PSDONE), 32'(k == 12));
        end
        check_wave(16, 8, 8, 8, 8'b0011_1100, 8'b0001_1110, 8'b1100_0011, "wave_ps_oor");

        // Decrement ch2 from dyn 0 wraps to P-1: total offset (6+7) mod 8 = 5.
        ps_request(2'd2, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) tick();
            chk("psdone_dec", 32'(PSDONE), 32'(k == 12));
        end
        check_wave(16, 8, 8, 8, 8'b0011_1100, 8'b0001_1110, 8'b1110_0001, "wave_ps_dec");

        // shift 360 -> 0, shift 181 on P=4 -> offset 2, duty 1 on P=8 clamps to 1 tick.
        cfg(8, 4, 8, 360, 181, 0, 50, 50, 1);
        do_load();
        chk("lock_drop", 32'(lock), 32'd0);
        check_wave(16, 8, 4, 8, 8'b0000_1111, 4'b1100, 8'b0000_0001, "wave_wrap_shift");

        cfg(100, 100, 100, 0, 0, 0, 1, 50, 99);
        do_load();
        check_wave(100, 100, 100, 100, lowmask(1), lowmask(50), lowmask(99), "wave_duty100");

        // Duty 99 on P=8 -> 7 ticks; periods 1 and 0 clamp to 2.
        cfg(8, 1, 0, 0, 0, 0, 99, 50, 99);
        do_load();
        check_wave(8, 8, 2, 2, 8'b0111_1111, 2'b01, 2'b01, "wave_clamp");

        // Multi-period channels, all aligned at shift 0; slowest lock at 3*12 wraps.
        cfg(6, 8, 12, 0, 0, 0, 50, 50, 50);
        do_load();
        check_wave(24, 6, 8, 12, 6'b00_0111, 8'b0000_1111, 12'b0000_0011_1111, "wave_multi");
        wait_lock(38, "lock_multi");

        // Load during a busy request: PSDONE on schedule, offset update dropped.
        ps_request(2'd0, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) tick();
            if (k == 6) begin load = 1'b0; cyc = 1; end
            chk("psdone_load", 32'(PSDONE), 32'(k == 12));
            if (k == 5) load = 1'b1;
        end
        check_wave(24, 6, 8, 12, 6'b00_0111, 8'b0000_1111, 12'b0000_0011_1111, "wave_load_busy");
        wait_lock(38, "lock_reload");

        // Power-down with a request in flight: everything low, no PSDONE, then restart.
        ps_request(2'd1, 1'b1);
        tick();
        PWRDWN = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("pd_clk", 32'(clk_shifted), 32'd0);
            chk("pd_lock", 32'(lock), 32'd0);
            chk("pd_psdone", 32'(PSDONE), 32'd0);
        end
        PWRDWN = 1'b0;
        cyc = 1;
        check_wave(24, 6, 8, 12, 6'b00_0111, 8'b0000_1111, 12'b0000_0011_1111, "wave_pwrdwn");
        wait_lock(38, "lock_pwrdwn");

        // Asynchronous reset between edges clears outputs immediately.
        #3 RST_N = 1'b0;
        #1;
        chk("areset_lock", 32'(lock), 32'd0);
        chk("areset_clk", 32'(clk_shifted), 32'd0);
        #2 RST_N = 1'b1;
        repeat (4) tick();
        chk("post_reset_clk", 32'(clk_shifted), 32'd0);
        chk("post_reset_lock", 32'(lock), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
